// File: rtl/icap_arb_pkg.sv
// Shared definitions for the ICAP frame arbiter: FSM state encoding, owner
// identifiers and the round-robin pick used when the port is idle.
package icap_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // On a tie the requester that did not hold the last grant wins.
  function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last);
    if (req_a && req_b) begin
      return ~last;
    end else if (req_a) begin
      return OWNER_A;
    end else begin
      return OWNER_B;
    end
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog for the ICAP frame arbiter.
// Counts consecutive cycles without a beat while a grant is held and fires
// when the count reaches TIMEOUT (TIMEOUT = 0 disables it).
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   active_i       a grant is currently held
//   beat_i         a beat transferred on the granted path this cycle
//   fire_o         combinational: the grant must be dropped at this edge
//   abort_o        registered one-cycle pulse following a fire
//   abort_cnt_o    saturating count of fires
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             active_i,
  input  logic             beat_i,
  output logic             fire_o,
  output logic             abort_o,
  output logic [CNT_W-1:0] abort_cnt_o
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // The counter only needs to reach TIMEOUT-1: the stalled cycle that would
  // make it TIMEOUT is the one that fires.
  localparam logic [WdW-1:0] CntLast = (TIMEOUT == 0) ? '0 : WdW'(TIMEOUT - 1);

  logic [WdW-1:0]   cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;

  always_comb begin
    fire_o      = (TIMEOUT != 0) && active_i && !beat_i && (cnt_q == CntLast);
    cnt_d       = cnt_q;
    abort_d     = fire_o;
    abort_cnt_d = abort_cnt_q;
    if (!active_i || beat_i || fire_o || (TIMEOUT == 0)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WdW'(1);
    end
    if (fire_o && (abort_cnt_q != '1)) begin
      abort_cnt_d = abort_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_o     = abort_q;
  assign abort_cnt_o = abort_cnt_q;

endmodule

// File: rtl/icap_frame_arbiter.sv
// Shares the single ICAP port buffer between channel A (write path) and
// channel B (readback path). One requester is granted per frame, round-robin,
// and the grant is held until the matching response frame has drained back.
//   clk, rst_n                 clock (clk_local) and async active-low reset
//   a_*/b_* in_*               request stream from each requester
//   a_*/b_* out_*              response stream to each requester
//   icap_in_*                  request stream to the ICAP buffer
//   icap_out_*                 response stream from the ICAP buffer
//   icap_en_wr / icap_en_rd    buffer write / read enable for the owner
//   owner, busy                grant status (owner valid when busy)
//   abort, abort_cnt           watchdog pulse and saturating abort count
module icap_frame_arbiter
  import icap_arb_pkg::*;
#(
  parameter bit          RESP_EN = 1'b1,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_en,
  input  logic             b_en,
  input  logic [7:0]       a_in_data,
  input  logic [7:0]       b_in_data,
  input  logic             a_in_sof,
  input  logic             a_in_eof,
  input  logic             b_in_sof,
  input  logic             b_in_eof,
  input  logic             a_in_src_rdy,
  input  logic             b_in_src_rdy,
  output logic             a_in_dst_rdy,
  output logic             b_in_dst_rdy,
  output logic [7:0]       a_out_data,
  output logic [7:0]       b_out_data,
  output logic             a_out_sof,
  output logic             a_out_eof,
  output logic             b_out_sof,
  output logic             b_out_eof,
  output logic             a_out_src_rdy,
  output logic             b_out_src_rdy,
  input  logic             a_out_dst_rdy,
  input  logic             b_out_dst_rdy,
  output logic [7:0]       icap_in_data,
  output logic             icap_in_sof,
  output logic             icap_in_eof,
  output logic             icap_in_src_rdy,
  input  logic             icap_in_dst_rdy,
  output logic             icap_en_wr,
  output logic             icap_en_rd,
  input  logic [7:0]       icap_out_data,
  input  logic             icap_out_sof,
  input  logic             icap_out_eof,
  input  logic             icap_out_src_rdy,
  output logic             icap_out_dst_rdy,
  output logic             owner,
  output logic             busy,
  output logic             abort,
  output logic [CNT_W-1:0] abort_cnt
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic       req_a, req_b;
  logic       active;
  logic [7:0] own_data;
  logic       own_sof, own_eof, own_src_rdy, own_out_dst_rdy;
  logic       in_beat, out_beat;
  logic       wd_fire;

  assign req_a  = a_en & a_in_src_rdy & a_in_sof;
  assign req_b  = b_en & b_in_src_rdy & b_in_sof;
  assign active = (state_q != StIdle);

  // Owner's request and response-ready, selected once for both paths.
  always_comb begin
    if (owner_q == OWNER_B) begin
      own_data        = b_in_data;
      own_sof         = b_in_sof;
      own_eof         = b_in_eof;
      own_src_rdy     = b_in_src_rdy;
      own_out_dst_rdy = b_out_dst_rdy;
    end else begin
      own_data        = a_in_data;
      own_sof         = a_in_sof;
      own_eof         = a_in_eof;
      own_src_rdy     = a_in_src_rdy;
      own_out_dst_rdy = a_out_dst_rdy;
    end
  end

  assign in_beat  = (state_q == StReq) & own_src_rdy & icap_in_dst_rdy;
  assign out_beat = (state_q == StResp) & icap_out_src_rdy & own_out_dst_rdy;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .active_i    (active),
    .beat_i      (in_beat | out_beat),
    .fire_o      (wd_fire),
    .abort_o     (abort),
    .abort_cnt_o (abort_cnt)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          owner_d = rr_pick(req_a, req_b, last_q);
          state_d = StReq;
        end
      end
      StReq: begin
        if (in_beat && own_eof) begin
          state_d = RESP_EN ? StResp : StIdle;
        end
      end
      StResp: begin
        if (out_beat && icap_out_eof) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (wd_fire) begin
      state_d = StIdle;
    end
    // Any release (normal or abort) records who just finished.
    if (active && (state_d == StIdle)) begin
      last_d = owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= OWNER_A;
      last_q  <= OWNER_B;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Datapath routing; everything not explicitly routed stays at zero.
  always_comb begin
    a_in_dst_rdy     = 1'b0;
    b_in_dst_rdy     = 1'b0;
    a_out_data       = '0;
    a_out_sof        = 1'b0;
    a_out_eof        = 1'b0;
    a_out_src_rdy    = 1'b0;
    b_out_data       = '0;
    b_out_sof        = 1'b0;
    b_out_eof        = 1'b0;
    b_out_src_rdy    = 1'b0;
    icap_in_data     = '0;
    icap_in_sof      = 1'b0;
    icap_in_eof      = 1'b0;
    icap_in_src_rdy  = 1'b0;
    icap_out_dst_rdy = 1'b0;
    icap_en_wr       = active & (owner_q == OWNER_A);
    icap_en_rd       = active & (owner_q == OWNER_B);

    if (state_q == StReq) begin
      // Framing passes through untouched; a mid-frame sof is not reframed.
      icap_in_data    = own_data;
      icap_in_sof     = own_sof;
      icap_in_eof     = own_eof;
      icap_in_src_rdy = own_src_rdy;
      if (owner_q == OWNER_B) begin
        b_in_dst_rdy = icap_in_dst_rdy;
      end else begin
        a_in_dst_rdy = icap_in_dst_rdy;
      end
    end

    if (state_q == StResp) begin
      icap_out_dst_rdy = own_out_dst_rdy;
      if (owner_q == OWNER_B) begin
        b_out_data    = icap_out_data;
        b_out_sof     = icap_out_sof;
        b_out_eof     = icap_out_eof;
        b_out_src_rdy = icap_out_src_rdy;
      end else begin
        a_out_data    = icap_out_data;
        a_out_sof     = icap_out_sof;
        a_out_eof     = icap_out_eof;
        a_out_src_rdy = icap_out_src_rdy;
      end
    end
  end

  assign owner = owner_q;
  assign busy  = active;

endmodule

// File: doc/icap_frame_arbiter.md
Name: icap_frame_arbiter

Overview:
- Shares the single ICAP port buffer between two channel requesters, A (write path) and B (readback path).
- Grants the port one frame at a time, round-robin, and holds the grant until the matching response frame from the ICAP buffer has drained back to the same requester.
- Replaces the OR-combining of the two channels at the ICAP buffer, so simultaneous frames can no longer corrupt each other.
- Sits between channelif6 channel ports 3/4 and port_icap_buf, all in the clk_local domain.

Parameters:
- RESP_EN, 1: 1 = hold grant through one response frame; 0 = release after request eof.
- TIMEOUT, 4096: idle cycles (no beat transferred) tolerated inside a grant before abort; 0 disables the watchdog.
- CNT_W, 8: width of the abort counter.

Ports:
- clk  in  1  system clock (clk_local)
- rst_n  in  1  asynchronous active-low reset
- a_en, b_en  in  1 each  channel enable (wen/ren of the channel)
- a_in_data, b_in_data  in  8 each  request data from requester
- a_in_sof, a_in_eof, b_in_sof, b_in_eof  in  1 each  request framing
- a_in_src_rdy, b_in_src_rdy  in  1 each  request valid
- a_in_dst_rdy, b_in_dst_rdy  out  1 each  request accept
- a_out_data, b_out_data  out  8 each  response data to requester
- a_out_sof, a_out_eof, b_out_sof, b_out_eof  out  1 each  response framing
- a_out_src_rdy, b_out_src_rdy  out  1 each  response valid
- a_out_dst_rdy, b_out_dst_rdy  in  1 each  requester ready for response
- icap_in_data  out  8  to ICAP buffer
- icap_in_sof, icap_in_eof, icap_in_src_rdy  out  1 each  to ICAP buffer
- icap_in_dst_rdy  in  1  from ICAP buffer
- icap_en_wr  out  1  ICAP buffer write enable
- icap_en_rd  out  1  ICAP buffer read enable
- icap_out_data  in  8  response data from ICAP buffer
- icap_out_sof, icap_out_eof, icap_out_src_rdy  in  1 each  response framing/valid
- icap_out_dst_rdy  out  1  to ICAP buffer
- owner  out  1  0 = A, 1 = B (valid when busy)
- busy  out  1  grant held
- abort  out  1  one-cycle pulse on watchdog abort
- abort_cnt  out  CNT_W  saturating abort count

Behaviour:
- Beat transfer = src_rdy & dst_rdy, sampled on posedge clk. All handshakes are active high.
- Reset (rst_n low, async):
  - state = IDLE; last = B, so A wins the first tie.
  - owner = 0, busy = 0, abort = 0, abort_cnt = 0, watchdog = 0.
  - All dst_rdy/src_rdy outputs are 0 while reset is asserted.
- Request condition: reqX = x_en & x_in_src_rdy & x_in_sof.
- State IDLE:
  - All dst_rdy/src_rdy outputs are 0; data outputs are 0.
  - If either req is set, register owner (round-robin: on a tie, pick the requester other than last) and go to REQ. Grant latency is 1 cycle.
- State REQ:
  - Owner's request signals pass combinationally to icap_in_*; the owner's in_dst_rdy = icap_in_dst_rdy. The non-owner's dst_rdy = 0.
  - icap_en_wr = (owner == A); icap_en_rd = (owner == B). These stay asserted through REQ and RESP.
  - On a transfer with in_eof: if RESP_EN, go to RESP; else go to IDLE.
- State RESP:
  - icap_out_* routes to the owner's out_*; icap_out_dst_rdy = owner's out_dst_rdy. The non-owner's out_src_rdy = 0.
  - On a transfer with icap_out_eof, go to IDLE.
- On every return to IDLE: last <= owner, busy falls.
- Sof on the owner's request in the middle of a frame is passed through unchanged; the arbiter does not reframe.
- Dropping x_en while granted has no effect until the grant is released.
- Watchdog:
  - In REQ/RESP the counter increments each cycle with no transfer and clears on any transfer.
  - When it reaches TIMEOUT: state -> IDLE, abort = 1 for one cycle, abort_cnt += 1 (saturates at all-ones), last <= owner.
- Simultaneous req events are resolved only in IDLE; a request arriving on the same cycle as a release is serviced on the next IDLE cycle. Minimum gap between grants is 1 idle cycle.
- busy = (state != IDLE). Status outputs are registered.

Decomposition:
- Shared package icap_arb_pkg holds: the state encoding (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2), and OWNER_A = 1'b0, OWNER_B = 1'b1.
- One natural sub-module: arb_watchdog (counter, TIMEOUT compare, abort pulse, saturating abort_cnt).
- The muxing and FSM remain in the top.

Test Plan:
- A single write: A sends a 4-byte frame 0x11..0x44 → icap_in_* mirrors it one cycle after the request and icap_en_wr = 1. The ICAP 2-byte response 0xAA, 0xBB appears only on a_out_*. busy drops the cycle after the response eof.
- Tie: A and B both request in the same cycle after reset → A is granted first. After A's response eof, B is granted after 1 idle cycle, and icap_en_rd = 1 during B's grant.
- Non-owner blocking: B holds a request during A's grant → b_in_dst_rdy stays 0 throughout and b_out_src_rdy stays 0 even while icap_out_src_rdy = 1.
- Backpressure: icap_in_dst_rdy toggles 1/0 during A's frame → every byte arrives exactly once and in order; owner stays A.
- Watchdog: with TIMEOUT = 16, A sends sof but the ICAP never responds → at 16 stalled cycles, abort pulses once, abort_cnt = 1, state returns to IDLE, and the next grant goes to B if B is requesting.
- Async reset: drop rst_n mid-RESP → all src_rdy/dst_rdy outputs are 0 immediately, without waiting for a clock edge. After release, the first tie is granted to A.
